// File: rtl/fhe_cmd_issuer_pkg.sv
// Shared types and helpers for the FHE command issuer: command port layout,
// issuer FSM states and the blocking-command decode.
package fhe_cmd_issuer_pkg;

    localparam int COMMAND_WIDTH    = 8;
    localparam int FSIZE            = 32;
    localparam int CMD_ISSUER_DEPTH = 16;
    localparam int CMD_ENTRY_WIDTH  = COMMAND_WIDTH + 2 * FSIZE;

    localparam logic [COMMAND_WIDTH-1:0] COMMAND_RESET = 8'd111;

    typedef struct packed {
        logic                     valid;
        logic [COMMAND_WIDTH-1:0] command;
        logic [FSIZE-1:0]         data0;
        logic [FSIZE-1:0]         data1;
    } CommandDataPort;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_WAIT_DONE,
        ISS_ERROR
    } IssuerState;

    // NTT/INTT style runs (41-44, 51-58) hold the ALU until it reports done.
    function automatic logic is_blocking_cmd(input logic [COMMAND_WIDTH-1:0] cmd);
        return ((cmd >= 8'd41) && (cmd <= 8'd44)) ||
               ((cmd >= 8'd51) && (cmd <= 8'd58));
    endfunction

endpackage

// File: rtl/fhe_cmd_issuer_if.sv
// Host-facing command queue port plus the ALU command/done link of the issuer.
interface fhe_cmd_issuer_if #(
    parameter int FIFO_DEPTH = 16
);
    import fhe_cmd_issuer_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                     i_cmd_valid;
    logic                     o_cmd_ready;
    logic [COMMAND_WIDTH-1:0] i_cmd;
    logic [FSIZE-1:0]         i_data0;
    logic [FSIZE-1:0]         i_data1;
    CommandDataPort           o_cmd;
    logic                     i_alu_done;
    logic                     i_flush;
    logic                     i_err_clear;
    logic [CNT_W-1:0]         o_count;
    logic                     o_idle;
    logic                     o_timeout_err;

    modport master (
        output i_cmd_valid, i_cmd, i_data0, i_data1, i_alu_done, i_flush, i_err_clear,
        input  o_cmd_ready, o_cmd, o_count, o_idle, o_timeout_err
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_data0, i_data1, i_alu_done, i_flush, i_err_clear,
        output o_cmd_ready, o_cmd, o_count, o_idle, o_timeout_err
    );

endinterface

// File: rtl/fhe_cmd_fifo.sv
// Synchronous command queue: array storage with a registered read port that
// holds the last popped entry, separate occupancy counter, synchronous flush.
module fhe_cmd_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 72,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // A flush wins over both ports: the same-cycle push is dropped.
    assign push_ok = wr_en && !full && !flush;
    assign pop_ok  = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/fhe_cmd_issuer.sv
// Issues queued host commands to the FHE ALU, one valid pulse per command,
// stalling after blocking commands until done or a timeout error.
module fhe_cmd_issuer
    import fhe_cmd_issuer_pkg::*;
#(
    parameter int FIFO_DEPTH     = CMD_ISSUER_DEPTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            rst,
    fhe_cmd_issuer_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    IssuerState                 state_reg;
    IssuerState                 state_next;
    logic [TMR_W-1:0]           timer_reg;
    logic [TMR_W-1:0]           timer_next;
    logic [TMR_W-1:0]           timer_eff;
    logic                       valid_reg;
    logic                       pop;
    logic                       blk_pulse;
    logic                       waiting;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CMD_ENTRY_WIDTH-1:0] head_data;

    fhe_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.i_flush),
        .wr_en   (bus.i_cmd_valid),
        .wr_data ({bus.i_cmd, bus.i_data0, bus.i_data1}),
        .rd_en   (pop),
        .rd_data (head_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The popped entry is only visible one cycle later (registered read), so the
    // cycle carrying a blocking pulse is treated as the first wait cycle, timer 0.
    assign blk_pulse = valid_reg && is_blocking_cmd(head_data[CMD_ENTRY_WIDTH-1 -: COMMAND_WIDTH]);
    assign waiting   = (state_reg == ISS_WAIT_DONE) || ((state_reg == ISS_IDLE) && blk_pulse);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        timer_eff  = (state_reg == ISS_WAIT_DONE) ? timer_reg : '0;
        pop        = 1'b0;

        if (waiting) begin
            if (bus.i_alu_done) begin
                state_next = ISS_IDLE;
            end else if (timer_eff == TMR_LAST) begin
                state_next = ISS_ERROR;
            end else begin
                state_next = ISS_WAIT_DONE;
                timer_next = timer_eff + 1'b1;
            end
        end else if ((state_reg == ISS_ERROR) && bus.i_err_clear) begin
            state_next = ISS_IDLE;
        end

        // Leaving a stall pops on the same edge, so the next pulse lands one cycle later.
        pop = !fifo_empty && !bus.i_flush &&
              ((waiting && bus.i_alu_done) ||
               ((state_reg == ISS_IDLE) && !blk_pulse) ||
               ((state_reg == ISS_ERROR) && bus.i_err_clear));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ISS_IDLE;
            timer_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            valid_reg <= pop;
        end
    end

    assign bus.o_cmd         = {valid_reg, head_data};
    assign bus.o_cmd_ready   = !fifo_full;
    assign bus.o_count       = fifo_count;
    assign bus.o_idle        = fifo_empty && (state_reg == ISS_IDLE) && !blk_pulse;
    assign bus.o_timeout_err = (state_reg == ISS_ERROR);

endmodule

// File: tb/tb_fhe_cmd_issuer.sv
// Scoreboard bench for fhe_cmd_issuer: a main instance with a long timeout and a
// second instance with an 8-cycle timeout for the watchdog scenario.
module tb_fhe_cmd_issuer;
    import fhe_cmd_issuer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fhe_cmd_issuer_if #(.FIFO_DEPTH(16)) b1 ();
    fhe_cmd_issuer_if #(.FIFO_DEPTH(16)) b2 ();

    fhe_cmd_issuer #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(65535)) dut (
        .clk (clk), .rst (rst), .bus (b1)
    );
    fhe_cmd_issuer #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(8)) dut_t (
        .clk (clk), .rst (rst), .bus (b2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [71:0] q1 [$];
    logic [71:0] q2 [$];
    int          iss_cyc1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: every valid pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && b1.o_cmd.valid) begin
            iss_cyc1.push_back(cyc);
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_issue actual=%0h required=none", b1.o_cmd[71:0]);
            end else begin
                chk("dut1_issue", {1'b0, b1.o_cmd[71:0]}, {1'b0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b2.o_cmd.valid) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_unexpected_issue actual=%0h required=none", b2.o_cmd[71:0]);
            end else begin
                chk("dut2_issue", {1'b0, b2.o_cmd[71:0]}, {1'b0, q2.pop_front()});
            end
        end
    end

    task automatic push1(input logic [7:0] c, input logic [31:0] d0, input logic [31:0] d1, input bit expect_issue);
        @(posedge clk); #1;
        b1.i_cmd_valid = 1'b1; b1.i_cmd = c; b1.i_data0 = d0; b1.i_data1 = d1;
        if (expect_issue) q1.push_back({c, d0, d1});
    endtask

    task automatic rel1();
        @(posedge clk); #1;
        b1.i_cmd_valid = 1'b0; b1.i_flush = 1'b0; b1.i_alu_done = 1'b0; b1.i_err_clear = 1'b0;
    endtask

    task automatic push2(input logic [7:0] c, input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk); #1;
        b2.i_cmd_valid = 1'b1; b2.i_cmd = c; b2.i_data0 = d0; b2.i_data1 = d1;
        q2.push_back({c, d0, d1});
    endtask

    task automatic rel2();
        @(posedge clk); #1;
        b2.i_cmd_valid = 1'b0; b2.i_flush = 1'b0; b2.i_alu_done = 1'b0; b2.i_err_clear = 1'b0;
    endtask

    task automatic done1();
        @(posedge clk); #1; b1.i_alu_done = 1'b1;
        @(posedge clk); #1; b1.i_alu_done = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget, input string name);
        int n;
        logic idle;
        n = 0;
        @(negedge clk);
        idle = (which == 1) ? b1.o_idle : b2.o_idle;
        while (!idle && n < budget) begin
            @(negedge clk);
            idle = (which == 1) ? b1.o_idle : b2.o_idle;
            n++;
        end
        chk(name, idle, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_cmd"},   b1.o_cmd, 0);
        chk({tag, "_ready"}, b1.o_cmd_ready, 1);
        chk({tag, "_count"}, b1.o_count, 0);
        chk({tag, "_idle"},  b1.o_idle, 1);
        chk({tag, "_err"},   b1.o_timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        b1.i_cmd_valid = 0; b1.i_cmd = 0; b1.i_data0 = 0; b1.i_data1 = 0;
        b1.i_alu_done = 0; b1.i_flush = 0; b1.i_err_clear = 0;
        b2.i_cmd_valid = 0; b2.i_cmd = 0; b2.i_data0 = 0; b2.i_data1 = 0;
        b2.i_alu_done = 0; b2.i_flush = 0; b2.i_err_clear = 0;

        // Reset values
        @(negedge clk);
        chk_reset1("reset");
        chk("reset_dut2_cmd", b2.o_cmd, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: three back-to-back non-blocking commands
        iss_cyc1.delete();
        push1(8'd64, 32'd1, 32'd2, 1);
        push1(8'd66, 32'd3, 32'd4, 1);
        push1(8'd72, 32'd5, 32'd6, 1);
        rel1();
        wait_idle(1, 20, "t1_idle");
        chk("t1_pulses", iss_cyc1.size(), 3);
        if (iss_cyc1.size() == 3) chk("t1_consecutive", iss_cyc1[2] - iss_cyc1[0], 2);

        // 2: blocking 41 then 64; 64 must wait for done
        push1(8'd41, 32'd0, 32'd0, 1);
        push1(8'd64, 32'd7, 32'd8, 1);
        rel1();
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t2_held_count", b1.o_count, 1);
        chk("t2_no_early_issue", b1.o_cmd.valid, 0);
        @(posedge clk); #1 b1.i_alu_done = 1'b1;
        @(posedge clk); #1 b1.i_alu_done = 1'b0;
        @(negedge clk);
        chk("t2_issue_after_done", {b1.o_cmd.valid, b1.o_cmd.command}, {1'b1, 8'd64});
        wait_idle(1, 20, "t2_idle");

        // 3: timeout on the 8-cycle instance, pushes during ERROR, then clear
        push2(8'd51, 32'd0, 32'd0);
        rel2();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t3_err_before_limit", b2.o_timeout_err, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t3_err_at_limit", b2.o_timeout_err, 1);
        push2(8'd66, 32'd9, 32'd9);
        push2(8'd67, 32'd1, 32'd1);
        rel2();
        @(negedge clk);
        chk("t3_count_in_error", b2.o_count, 2);
        chk("t3_err_sticky", b2.o_timeout_err, 1);
        @(posedge clk); #1 b2.i_err_clear = 1'b1;
        @(posedge clk); #1 b2.i_err_clear = 1'b0;
        @(negedge clk);
        chk("t3_issue_after_clear", {b2.o_cmd.valid, b2.o_cmd.command}, {1'b1, 8'd66});
        chk("t3_err_cleared", b2.o_timeout_err, 0);
        wait_idle(2, 20, "t3_idle");

        // 4: fill 16 while stalled, 17th ignored, drain in order after done
        push1(8'd41, 32'd0, 32'd0, 1);
        rel1();
        repeat (3) @(posedge clk);
        for (int i = 0; i < 16; i++) push1(8'(60 + i), 32'(i * 3), 32'(i * 5), 1);
        push1(8'd99, 32'hdead, 32'hbeef, 0);
        rel1();
        @(negedge clk);
        chk("t4_full_count", b1.o_count, 16);
        chk("t4_full_ready", b1.o_cmd_ready, 0);
        done1();
        wait_idle(1, 60, "t4_drained");

        // 5: reset while waiting with 5 queued
        push1(8'd41, 32'd0, 32'd0, 1);
        rel1();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) push1(8'(80 + i), 32'(i), 32'(i), 0);
        rel1();
        @(negedge clk);
        chk("t5_queued", b1.o_count, 5);
        #2 rst = 1'b1;
        #1 chk_reset1("t5_rst");
        q1.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t5_idle_after", b1.o_idle, 1);

        // 6: flush with same-cycle push, then stray done in IDLE
        push1(8'd41, 32'd0, 32'd0, 1);
        rel1();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) push1(8'(70 + i), 32'(i), 32'(i), 0);
        @(posedge clk); #1;
        b1.i_cmd_valid = 1'b1; b1.i_cmd = 8'd74; b1.i_flush = 1'b1;
        rel1();
        @(negedge clk);
        chk("t6_flushed_count", b1.o_count, 0);
        chk("t6_still_waiting", b1.o_idle, 0);
        done1();
        repeat (3) @(negedge clk);
        chk("t6_idle_after_done", b1.o_idle, 1);
        done1();
        @(negedge clk);
        chk("t6_stray_done_idle", b1.o_idle, 1);
        chk("t6_stray_done_count", b1.o_count, 0);
        chk("t6_stray_done_err", b1.o_timeout_err, 0);
        push1(8'd111, 32'd1, 32'd1, 1);
        rel1();
        wait_idle(1, 20, "t6_final_idle");

        chk("end_q1_empty", q1.size(), 0);
        chk("end_q2_empty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
